// File: rtl/arcade_pause_ctrl.sv
// Pause/freeze arbiter for arcade cores: merges the user toggle, OSD pause and external freeze
// requests, drives the core PAUSE_N, grants requesters after a settle window and dims video.
module arcade_pause_ctrl #(
  parameter int unsigned CLK_HZ    = 48_000_000,
  parameter int unsigned DIM_SEC   = 10,
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned RGB_W     = 4,
  parameter int unsigned DIM_SHIFT = 1
) (
  input  logic               clk_sys_i,
  input  logic               reset_i,
  input  logic               pause_btn_i,
  input  logic               osd_open_i,
  input  logic               osd_pause_en_i,
  input  logic [N_SRC-1:0]   req_i,
  output logic [N_SRC-1:0]   grant_o,
  output logic               pause_n_o,
  output logic               user_paused_o,
  output logic               dim_o,
  input  logic [3*RGB_W-1:0] rgb_in_i,
  output logic [3*RGB_W-1:0] rgb_out_o
);

  localparam int unsigned DimMax  = CLK_HZ * DIM_SEC;
  localparam int unsigned TimerW  = $clog2(DimMax + 1);
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TimerW-1:0]  DimMaxT    = TimerW'(DimMax);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  typedef enum logic [1:0] {StRun, StStopping, StPaused} state_e;

  state_e               state_q, state_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [N_SRC-1:0]     grant_q, grant_d;
  logic [3*RGB_W-1:0]   rgb_q, rgb_d, rgb_dim;
  logic                 pause_n_q, pause_n_d;
  logic                 btn_q;
  logic                 user_q, user_d;
  logic                 dim_q, dim_d;
  logic                 cause;

  assign cause  = user_q | (osd_open_i & osd_pause_en_i) | (|req_i);
  assign user_d = user_q ^ (pause_btn_i & ~btn_q);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    pause_n_d = pause_n_q;
    grant_d   = '0;
    unique case (state_q)
      StRun: begin
        pause_n_d = 1'b1;
        if (cause) begin
          state_d   = StStopping;
          pause_n_d = 1'b0;
          settle_d  = '0;
        end
      end
      StStopping: begin
        settle_d = settle_q + SettleW'(1);
        if (!cause) begin
          state_d   = StRun;
          pause_n_d = 1'b1;
        end else if (settle_q == SettleLast) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (!cause) begin
          state_d   = StRun;
          pause_n_d = 1'b1;
        end else begin
          grant_d = req_i;
        end
      end
      default: begin
        state_d   = StRun;
        pause_n_d = 1'b1;
      end
    endcase
  end

  // Dim timer saturates so a long user pause holds dim without wrapping.
  always_comb begin
    timer_d = '0;
    if (user_q) begin
      timer_d = (timer_q == DimMaxT) ? timer_q : timer_q + TimerW'(1);
    end
    dim_d = (timer_q == DimMaxT);
  end

  always_comb begin
    rgb_dim = '0;
    for (int c = 0; c < 3; c++) begin
      rgb_dim[c*RGB_W +: RGB_W] = rgb_in_i[c*RGB_W +: RGB_W] >> DIM_SHIFT;
    end
    rgb_d = dim_q ? rgb_dim : rgb_in_i;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q   <= StRun;
      settle_q  <= '0;
      timer_q   <= '0;
      grant_q   <= '0;
      rgb_q     <= '0;
      pause_n_q <= 1'b1;
      btn_q     <= 1'b0;
      user_q    <= 1'b0;
      dim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      rgb_q     <= rgb_d;
      pause_n_q <= pause_n_d;
      btn_q     <= pause_btn_i;
      user_q    <= user_d;
      dim_q     <= dim_d;
    end
  end

  assign grant_o       = grant_q;
  assign pause_n_o     = pause_n_q;
  assign user_paused_o = user_q;
  assign dim_o         = dim_q;
  assign rgb_out_o     = rgb_q;

endmodule

// File: tb/tb_arcade_pause_ctrl.sv
// Scoreboard bench for arcade_pause_ctrl: a freeze-age reference model queues the expected
// outputs each cycle and an independent monitor compares them against the DUT.
module tb_arcade_pause_ctrl;

  localparam int unsigned CLK_HZ    = 100;
  localparam int unsigned DIM_SEC   = 1;
  localparam int unsigned N_SRC     = 2;
  localparam int unsigned SETTLE    = 4;
  localparam int unsigned RGB_W     = 4;
  localparam int unsigned DIM_SHIFT = 1;
  localparam int          DimMax    = CLK_HZ * DIM_SEC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pause_btn = 1'b0;
  logic        osd_open = 1'b0;
  logic        osd_pause_en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  grant;
  logic        pause_n;
  logic        user_paused;
  logic        dim;
  logic [11:0] rgb_in = 12'h000;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  arcade_pause_ctrl #(
    .CLK_HZ(CLK_HZ), .DIM_SEC(DIM_SEC), .N_SRC(N_SRC),
    .SETTLE(SETTLE), .RGB_W(RGB_W), .DIM_SHIFT(DIM_SHIFT)
  ) dut (
    .clk_sys_i     (clk),
    .reset_i       (reset),
    .pause_btn_i   (pause_btn),
    .osd_open_i    (osd_open),
    .osd_pause_en_i(osd_pause_en),
    .req_i         (req),
    .grant_o       (grant),
    .pause_n_o     (pause_n),
    .user_paused_o (user_paused),
    .dim_o         (dim),
    .rgb_in_i      (rgb_in),
    .rgb_out_o     (rgb_out)
  );

  typedef struct packed {
    logic [1:0]  grant;
    logic        pause_n;
    logic        user;
    logic        dim;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: m_age counts cycles since the core was told to freeze (-1 = running).
  int          m_age = -1;
  int          m_timer = 0;
  bit          m_user = 0, m_btn_prev = 0, m_dim = 0;
  logic [1:0]  m_grant = 2'b00;
  logic [11:0] m_rgb = 12'h000;

  function automatic logic [11:0] dimmed(input logic [11:0] v);
    int r = 0;
    for (int c = 0; c < 3; c++) begin
      int ch = (int'(v) >> (4 * c)) & 15;
      r = r | ((ch >> DIM_SHIFT) << (4 * c));
    end
    return 12'(r);
  endfunction

  task automatic step(input logic rst, input logic btn, input logic osd, input logic en,
                      input logic [1:0] rq, input logic [11:0] rgb);
    bit          cause, n_user, n_dim;
    int          n_age, n_timer;
    logic [1:0]  n_grant;
    logic [11:0] n_rgb;
    @(negedge clk);
    reset = rst; pause_btn = btn; osd_open = osd; osd_pause_en = en; req = rq; rgb_in = rgb;
    if (rst) begin
      m_age = -1; m_timer = 0; m_user = 0; m_btn_prev = 0; m_dim = 0;
      m_grant = 2'b00; m_rgb = 12'h000;
    end else begin
      cause  = m_user || (osd && en) || (rq != 2'b00);
      n_user = m_user ^ (btn && !m_btn_prev);
      if (!cause) begin
        n_age = -1; n_grant = 2'b00;
      end else if (m_age < 0) begin
        n_age = 0; n_grant = 2'b00;
      end else begin
        n_age   = m_age + 1;
        n_grant = (m_age >= int'(SETTLE)) ? rq : 2'b00;
      end
      n_timer = m_user ? ((m_timer < DimMax) ? m_timer + 1 : m_timer) : 0;
      n_dim   = (m_timer == DimMax);
      n_rgb   = m_dim ? dimmed(rgb) : rgb;
      m_age = n_age; m_grant = n_grant; m_user = n_user; m_btn_prev = btn;
      m_timer = n_timer; m_dim = n_dim; m_rgb = n_rgb;
    end
    q.push_back('{grant: m_grant, pause_n: (m_age < 0), user: m_user, dim: m_dim, rgb: m_rgb});
  endtask

  task automatic idle(input int n, input logic osd, input logic en, input logic [1:0] rq,
                      input logic [11:0] rgb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, osd, en, rq, rgb);
  endtask

  // Monitor: the DUT presents a fresh registered output after every edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{grant: grant, pause_n: pause_n, user: user_paused, dim: dim, rgb: rgb_out};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle=%0d got grant=%b pause_n=%b user=%b dim=%b rgb=%h expected grant=%b pause_n=%b user=%b dim=%b rgb=%h",
                   cycle, a.grant, a.pause_n, a.user, a.dim, a.rgb,
                   e.grant, e.pause_n, e.user, e.dim, e.rgb);
        end
      end
    end
  end

  initial begin
    logic       b, o, en, r;
    logic [1:0] rq;
    // Reset and basic request/grant latency.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 12'($urandom));
    idle(10, 1'b0, 1'b0, 2'b01, 12'h123);
    idle(5, 1'b0, 1'b0, 2'b00, 12'h456);
    // Held button toggles once; second press untoggles.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12'($urandom));
    idle(3, 1'b0, 1'b0, 2'b00, 12'h0AA);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12'h0BB);
    idle(8, 1'b0, 1'b0, 2'b00, 12'h0CC);
    // Long user pause dims video, unpause restores it.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12'hFA8);
    idle(110, 1'b0, 1'b0, 2'b00, 12'hFA8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12'hFA8);
    idle(8, 1'b0, 1'b0, 2'b00, 12'hFA8);
    // Request dropped mid-settle never grants.
    idle(2, 1'b0, 1'b0, 2'b10, 12'h111);
    idle(6, 1'b0, 1'b0, 2'b00, 12'h222);
    // OSD pause, gated by the enable.
    idle(10, 1'b1, 1'b1, 2'b00, 12'h333);
    idle(6, 1'b1, 1'b0, 2'b00, 12'h444);
    // Both channels granted, then reset mid-pause.
    idle(10, 1'b0, 1'b0, 2'b11, 12'h555);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 12'h666);
    idle(10, 1'b0, 1'b0, 2'b11, 12'h777);
    idle(3, 1'b0, 1'b0, 2'b01, 12'h777);
    idle(3, 1'b0, 1'b0, 2'b00, 12'h777);
    // Toggle-off coinciding with a new request keeps the core frozen.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 12'h888);
    idle(10, 1'b0, 1'b0, 2'b00, 12'h888);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 12'h999);
    idle(8, 1'b0, 1'b0, 2'b01, 12'h999);
    idle(4, 1'b0, 1'b0, 2'b00, 12'h999);
    // Randomized traffic.
    b = 0; o = 0; en = 0; rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) b = ~b;
      if ($urandom_range(29) == 0) o = ~o;
      if ($urandom_range(49) == 0) en = ~en;
      if ($urandom_range(14) == 0) rq[0] = ~rq[0];
      if ($urandom_range(14) == 0) rq[1] = ~rq[1];
      r = ($urandom_range(499) == 0);
      step(r, b, o, en, rq, 12'($urandom));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
